ft245_fifo_responder: RTL and testbench

//  Device-side model of the FT2232H async 245 FIFO. It answers the nRD/nWR strobes from the FPGA-side FIFO master,

---
 rtl/ft245_fifo_responder.sv | 194 +++++++++++++++++++
 tb/tb_ft245_fifo_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft245_fifo_responder.sv
// Device-side model of an FT2232H async 245 FIFO.
// The FPGA-side master strobes nRD_i/nWR_i against nRXF_o/nTXE_o over a shared
// 8-bit bus. A host port stands in for the PC: it feeds the RX FIFO and drains
// the TX FIFO. Both FIFOs use pointers one bit wider than the address so that
// full and empty can be told apart.
module ft245_fifo_responder #(
  parameter int DEPTH_LOG2 = 4,
  parameter int PRECHARGE  = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  inout  wire  [7:0] data_io,
  output logic       nRXF_o,
  output logic       nTXE_o,
  input  logic       nRD_i,
  input  logic       nWR_i,
  input  logic       host_wr_i,
  input  logic [7:0] host_wr_data_i,
  output logic       host_full_o,
  input  logic       host_rd_i,
  output logic [7:0] host_rd_data_o,
  output logic       host_empty_o,
  output logic       rd_err_o,
  output logic       wr_err_o,
  output logic       ovf_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [2:0] LAT_LOAD = 3'(RD_LATENCY - 1);
  localparam logic [3:0] PRE_LOAD = 4'(PRECHARGE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_PRE   = 2'd3
  } state_t;

  state_t          r_state;
  logic [3:0]      r_pre_cnt;
  logic [2:0]      r_lat_cnt;
  logic            r_drive;
  logic [7:0]      r_wr_byte;
  logic            r_nrd_q;
  logic            r_nwr_q;
  logic            r_alive;
  logic            r_rd_err;
  logic            r_wr_err;
  logic            r_ovf;
  logic [PW-1:0]   r_rx_wp;
  logic [PW-1:0]   r_rx_rp;
  logic [PW-1:0]   r_tx_wp;
  logic [PW-1:0]   r_tx_rp;
  logic [7:0]      r_rx_mem [DEPTH];
  logic [7:0]      r_tx_mem [DEPTH];

  logic w_rd_fall, w_rd_rise, w_wr_fall, w_wr_rise;
  logic w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic w_rd_ok, w_wr_ok, w_rd_bad, w_wr_bad;
  logic w_rx_push, w_rx_pop, w_tx_push, w_tx_pop, w_ovf;
  logic [7:0] w_rx_head;

  // Strobe edges: live sample against the previous clock's sample.
  assign w_rd_fall = r_nrd_q & ~nRD_i;
  assign w_rd_rise = ~r_nrd_q & nRD_i;
  assign w_wr_fall = r_nwr_q & ~nWR_i;
  assign w_wr_rise = ~r_nwr_q & nWR_i;

  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[PW-1] != r_rx_rp[PW-1]) &&
                      (r_rx_wp[PW-2:0] == r_rx_rp[PW-2:0]);
  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[PW-1] != r_tx_rp[PW-1]) &&
                      (r_tx_wp[PW-2:0] == r_tx_rp[PW-2:0]);

  // Flags stay busy until the first clock after reset, then follow state/occupancy.
  assign nRXF_o = ~r_alive | w_rx_empty | (r_state == ST_PRE) | (r_state == ST_WRITE);
  assign nTXE_o = ~r_alive | w_tx_full  | (r_state == ST_PRE) | (r_state == ST_READ);

  // Simultaneous falls on both strobes are never accepted.
  assign w_rd_ok  = (r_state == ST_IDLE) & w_rd_fall & ~nRXF_o & ~w_wr_fall;
  assign w_wr_ok  = (r_state == ST_IDLE) & w_wr_fall & ~nTXE_o & ~w_rd_fall;
  assign w_rd_bad = w_rd_fall & ~w_rd_ok;
  assign w_wr_bad = w_wr_fall & ~w_wr_ok;

  // A push into a full FIFO is accepted when a pop frees the slot in the same cycle.
  assign w_rx_pop  = (r_state == ST_READ) & w_rd_rise;
  assign w_rx_push = host_wr_i & (~w_rx_full | w_rx_pop);
  assign w_ovf     = host_wr_i & w_rx_full & ~w_rx_pop;
  assign w_tx_pop  = host_rd_i & ~w_tx_empty;
  assign w_tx_push = (r_state == ST_WRITE) & w_wr_rise & (~w_tx_full | w_tx_pop);

  assign w_rx_head      = r_rx_mem[r_rx_rp[DEPTH_LOG2-1:0]];
  assign host_rd_data_o = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rp[DEPTH_LOG2-1:0]];
  assign host_full_o    = w_rx_full;
  assign host_empty_o   = w_tx_empty;
  assign rd_err_o       = r_rd_err;
  assign wr_err_o       = r_wr_err;
  assign ovf_o          = r_ovf;

  // The bus is driven only from the registered enable, which reset clears at once.
  assign data_io = r_drive ? w_rx_head : 8'hzz;

  // Strobe protocol FSM: edge history, error pulses, read latency, write capture, precharge.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state   <= ST_IDLE;
      r_pre_cnt <= 4'd0;
      r_lat_cnt <= 3'd0;
      r_drive   <= 1'b0;
      r_wr_byte <= 8'h00;
      r_nrd_q   <= 1'b1;
      r_nwr_q   <= 1'b1;
      r_alive   <= 1'b0;
      r_rd_err  <= 1'b0;
      r_wr_err  <= 1'b0;
    end else begin
      r_nrd_q  <= nRD_i;
      r_nwr_q  <= nWR_i;
      r_alive  <= 1'b1;
      r_rd_err <= w_rd_bad;
      r_wr_err <= w_wr_bad;
      case (r_state)
        ST_IDLE: begin
          r_drive <= 1'b0;
          if (w_rd_ok) begin
            r_state   <= ST_READ;
            r_lat_cnt <= LAT_LOAD;
          end else if (w_wr_ok) begin
            r_state   <= ST_WRITE;
            r_wr_byte <= data_io;
          end
        end
        ST_READ: begin
          if (w_rd_rise) begin
            r_state   <= ST_PRE;
            r_drive   <= 1'b0;
            r_pre_cnt <= PRE_LOAD;
          end else if (r_lat_cnt == 3'd0) begin
            r_drive <= 1'b1;
          end else begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
          end
        end
        ST_WRITE: begin
          if (w_wr_rise) begin
            r_state   <= ST_PRE;
            r_pre_cnt <= PRE_LOAD;
          end else begin
            r_wr_byte <= data_io;
          end
        end
        ST_PRE: begin
          if (r_pre_cnt <= 4'd1) begin
            r_state   <= ST_IDLE;
            r_pre_cnt <= 4'd0;
          end else begin
            r_pre_cnt <= r_pre_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_drive <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and the overflow pulse.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_rx_wp <= '0;
      r_rx_rp <= '0;
      r_tx_wp <= '0;
      r_tx_rp <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= w_ovf;
      if (w_rx_push) r_rx_wp <= r_rx_wp + PW'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + PW'(1);
      if (w_tx_push) r_tx_wp <= r_tx_wp + PW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + PW'(1);
    end
  end

  // FIFO storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk_i) begin
    if (w_rx_push) r_rx_mem[r_rx_wp[DEPTH_LOG2-1:0]] <= host_wr_data_i;
    if (w_tx_push) r_tx_mem[r_tx_wp[DEPTH_LOG2-1:0]] <= r_wr_byte;
  end

endmodule

// File: tb/tb_ft245_fifo_responder.sv
// Bench for ft245_fifo_responder: host-side and master-side stimulus with random
// bytes and strobe lengths, checked against queue-based FIFO models.
module tb_ft245_fifo_responder;

  localparam int PRECHARGE = 2;
  localparam int DEPTH     = 16;

  logic       clk_i = 1'b0;
  logic       reset_ni = 1'b0;
  logic       nRD_i = 1'b1;
  logic       nWR_i = 1'b1;
  logic       host_wr_i = 1'b0;
  logic [7:0] host_wr_data_i = 8'h00;
  logic       host_rd_i = 1'b0;
  wire  [7:0] data_io;
  logic       nRXF_o, nTXE_o, host_full_o, host_empty_o;
  logic       rd_err_o, wr_err_o, ovf_o;
  logic [7:0] host_rd_data_o;

  // Bench side of the bus: drives 0 whenever the responder must be released,
  // so any stray drive from the responder shows up as a non-zero value.
  logic       tb_drv_en = 1'b1;
  logic [7:0] tb_data = 8'h00;
  assign data_io = tb_drv_en ? tb_data : 8'hzz;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  ft245_fifo_responder #(.DEPTH_LOG2(4), .PRECHARGE(PRECHARGE), .RD_LATENCY(1)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .data_io(data_io),
    .nRXF_o(nRXF_o), .nTXE_o(nTXE_o), .nRD_i(nRD_i), .nWR_i(nWR_i),
    .host_wr_i(host_wr_i), .host_wr_data_i(host_wr_data_i), .host_full_o(host_full_o),
    .host_rd_i(host_rd_i), .host_rd_data_o(host_rd_data_o), .host_empty_o(host_empty_o),
    .rd_err_o(rd_err_o), .wr_err_o(wr_err_o), .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic host_push(input logic [7:0] b);
    logic exp_ovf;
    exp_ovf = (rx_q.size() == DEPTH);
    host_wr_data_i = b;
    host_wr_i = 1'b1;
    tick();
    host_wr_i = 1'b0;
    if (!exp_ovf) rx_q.push_back(b);
    n_checks++; if (ovf_o !== exp_ovf) $display("FAIL push_ovf got=%b exp=%b", ovf_o, exp_ovf); else n_pass++;
    n_checks++; if (host_full_o !== (rx_q.size() == DEPTH)) $display("FAIL push_full got=%b exp=%b", host_full_o, rx_q.size() == DEPTH); else n_pass++;
  endtask

  task automatic host_pop();
    n_checks++; if (host_rd_data_o !== tx_q[0]) $display("FAIL pop_data got=%h exp=%h", host_rd_data_o, tx_q[0]); else n_pass++;
    host_rd_i = 1'b1;
    tick();
    host_rd_i = 1'b0;
    void'(tx_q.pop_front());
    n_checks++; if (host_empty_o !== (tx_q.size() == 0)) $display("FAIL pop_empty got=%b exp=%b", host_empty_o, tx_q.size() == 0); else n_pass++;
  endtask

  task automatic master_read(input int hold, input logic coincide);
    logic [7:0] exp_b;
    logic [7:0] extra;
    exp_b = rx_q[0];
    extra = 8'($urandom);
    n_checks++; if (nRXF_o !== 1'b0) $display("FAIL rd_ready nRXF got=%b exp=0", nRXF_o); else n_pass++;
    tb_drv_en = 1'b0;
    nRD_i = 1'b0;
    tick();
    tick();
    n_checks++; if (data_io !== exp_b) $display("FAIL rd_data got=%h exp=%h", data_io, exp_b); else n_pass++;
    for (int i = 0; i < hold; i++) begin
      tick();
      n_checks++; if (data_io !== exp_b) $display("FAIL rd_hold got=%h exp=%h", data_io, exp_b); else n_pass++;
    end
    nRD_i = 1'b1;
    if (coincide) begin
      host_wr_data_i = extra;
      host_wr_i = 1'b1;
    end
    tick();
    host_wr_i = 1'b0;
    tb_data = 8'h00;
    tb_drv_en = 1'b1;
    #1;
    void'(rx_q.pop_front());
    if (coincide) begin
      rx_q.push_back(extra);
      n_checks++; if (ovf_o !== 1'b0) $display("FAIL coinc_ovf got=%b exp=0", ovf_o); else n_pass++;
      n_checks++; if (host_full_o !== (rx_q.size() == DEPTH)) $display("FAIL coinc_full got=%b exp=%b", host_full_o, rx_q.size() == DEPTH); else n_pass++;
    end
    n_checks++; if (data_io !== 8'h00) $display("FAIL rd_release got=%h exp=00", data_io); else n_pass++;
    n_checks++; if (nRXF_o !== 1'b1) $display("FAIL rd_pre0 nRXF got=%b exp=1", nRXF_o); else n_pass++;
    for (int i = 1; i < PRECHARGE; i++) begin
      tick();
      n_checks++; if (nRXF_o !== 1'b1) $display("FAIL rd_pre nRXF got=%b exp=1", nRXF_o); else n_pass++;
    end
    tick();
    n_checks++; if (nRXF_o !== (rx_q.size() == 0)) $display("FAIL rd_after nRXF got=%b exp=%b", nRXF_o, rx_q.size() == 0); else n_pass++;
  endtask

  task automatic master_write(input logic [7:0] b, input int hold);
    n_checks++; if (nTXE_o !== 1'b0) $display("FAIL wr_ready nTXE got=%b exp=0", nTXE_o); else n_pass++;
    tb_drv_en = 1'b1;
    tb_data = 8'($urandom);
    nWR_i = 1'b0;
    tick();
    for (int i = 0; i < hold; i++) begin
      tb_data = 8'($urandom);
      tick();
    end
    tb_data = b;
    tick();
    nWR_i = 1'b1;
    tb_data = ~b;
    tick();
    tx_q.push_back(b);
    n_checks++; if (nTXE_o !== 1'b1) $display("FAIL wr_pre0 nTXE got=%b exp=1", nTXE_o); else n_pass++;
    n_checks++; if (wr_err_o !== 1'b0) $display("FAIL wr_noerr got=%b exp=0", wr_err_o); else n_pass++;
    for (int i = 1; i < PRECHARGE; i++) begin
      tick();
      n_checks++; if (nTXE_o !== 1'b1) $display("FAIL wr_pre nTXE got=%b exp=1", nTXE_o); else n_pass++;
    end
    tick();
    tb_data = 8'h00;
    n_checks++; if (nTXE_o !== (tx_q.size() == DEPTH)) $display("FAIL wr_after nTXE got=%b exp=%b", nTXE_o, tx_q.size() == DEPTH); else n_pass++;
    n_checks++; if (host_empty_o !== 1'b0) $display("FAIL wr_nonempty got=%b exp=0", host_empty_o); else n_pass++;
  endtask

  task automatic bad_strobe(input logic do_rd, input logic do_wr);
    tb_drv_en = 1'b1;
    tb_data = 8'h00;
    if (do_rd) nRD_i = 1'b0;
    if (do_wr) nWR_i = 1'b0;
    tick();
    n_checks++; if (rd_err_o !== do_rd) $display("FAIL bad_rd_err got=%b exp=%b", rd_err_o, do_rd); else n_pass++;
    n_checks++; if (wr_err_o !== do_wr) $display("FAIL bad_wr_err got=%b exp=%b", wr_err_o, do_wr); else n_pass++;
    n_checks++; if (data_io !== 8'h00) $display("FAIL bad_bus got=%h exp=00", data_io); else n_pass++;
    tick();
    n_checks++; if ((rd_err_o | wr_err_o) !== 1'b0) $display("FAIL bad_pulse_len got=%b exp=0", rd_err_o | wr_err_o); else n_pass++;
    nRD_i = 1'b1;
    nWR_i = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if ({nRXF_o, nTXE_o} !== 2'b11) $display("FAIL rst_flags got=%b exp=11", {nRXF_o, nTXE_o}); else n_pass++;
    n_checks++; if ({host_full_o, host_empty_o} !== 2'b01) $display("FAIL rst_host got=%b exp=01", {host_full_o, host_empty_o}); else n_pass++;
    n_checks++; if (host_rd_data_o !== 8'h00) $display("FAIL rst_rd_data got=%h exp=00", host_rd_data_o); else n_pass++;
    n_checks++; if ({rd_err_o, wr_err_o, ovf_o} !== 3'b000) $display("FAIL rst_pulses got=%b exp=000", {rd_err_o, wr_err_o, ovf_o}); else n_pass++;
    n_checks++; if (data_io !== 8'h00) $display("FAIL rst_bus got=%h exp=00", data_io); else n_pass++;
    reset_ni = 1'b1;
    tick();
    tick();
    n_checks++; if ({nRXF_o, nTXE_o} !== 2'b10) $display("FAIL post_rst_flags got=%b exp=10", {nRXF_o, nTXE_o}); else n_pass++;
  endtask

  task automatic test_basic_read();
    host_push(8'h85);
    host_push(8'h12);
    master_read(int'($urandom_range(0, 3)), 1'b0);
    master_read(int'($urandom_range(0, 3)), 1'b0);
  endtask

  task automatic test_basic_write();
    master_write(8'hC0, int'($urandom_range(0, 3)));
    master_write(8'h3F, int'($urandom_range(0, 3)));
    host_pop();
    host_pop();
  endtask

  task automatic test_illegal();
    bad_strobe(1'b1, 1'b0);
    n_checks++; if (nRXF_o !== 1'b1) $display("FAIL empty_rx_nRXF got=%b exp=1", nRXF_o); else n_pass++;
    host_push(8'($urandom));
    bad_strobe(1'b1, 1'b1);
    n_checks++; if ({nRXF_o, nTXE_o} !== 2'b00) $display("FAIL both_idle got=%b exp=00", {nRXF_o, nTXE_o}); else n_pass++;
    master_read(0, 1'b0);
  endtask

  task automatic test_tx_full();
    for (int i = 0; i < DEPTH; i++) master_write(8'($urandom), int'($urandom_range(0, 2)));
    bad_strobe(1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) host_pop();
  endtask

  task automatic test_rx_full();
    for (int i = 0; i <= DEPTH; i++) host_push(8'($urandom));
    master_read(int'($urandom_range(0, 2)), 1'b1);
    for (int i = 0; i < DEPTH; i++) master_read(0, 1'b0);
  endtask

  task automatic test_reset_mid_read();
    host_push(8'($urandom));
    host_push(8'($urandom));
    tb_drv_en = 1'b0;
    nRD_i = 1'b0;
    tick();
    tick();
    n_checks++; if (data_io !== rx_q[0]) $display("FAIL mid_rd_data got=%h exp=%h", data_io, rx_q[0]); else n_pass++;
    reset_ni = 1'b0;
    #1;
    tb_data = 8'h00;
    tb_drv_en = 1'b1;
    #1;
    rx_q.delete();
    tx_q.delete();
    n_checks++; if (data_io !== 8'h00) $display("FAIL mid_rst_bus got=%h exp=00", data_io); else n_pass++;
    n_checks++; if ({nRXF_o, nTXE_o} !== 2'b11) $display("FAIL mid_rst_flags got=%b exp=11", {nRXF_o, nTXE_o}); else n_pass++;
    n_checks++; if ({host_full_o, host_empty_o} !== 2'b01) $display("FAIL mid_rst_host got=%b exp=01", {host_full_o, host_empty_o}); else n_pass++;
    nRD_i = 1'b1;
    tick();
    reset_ni = 1'b1;
    tick();
    tick();
    n_checks++; if (nRXF_o !== 1'b1) $display("FAIL post_mid_nRXF got=%b exp=1", nRXF_o); else n_pass++;
    host_push(8'($urandom));
    host_push(8'($urandom));
    master_read(int'($urandom_range(0, 3)), 1'b0);
    master_read(int'($urandom_range(0, 3)), 1'b0);
  endtask

  task automatic test_random();
    int op;
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0: host_push(8'($urandom));
        1: if (tx_q.size() != 0) host_pop();
        2: if (rx_q.size() != 0) master_read(int'($urandom_range(0, 3)), 1'($urandom));
           else bad_strobe(1'b1, 1'b0);
        default: if (tx_q.size() < DEPTH) master_write(8'($urandom), int'($urandom_range(0, 3)));
                 else bad_strobe(1'b0, 1'b1);
      endcase
    end
    while (tx_q.size() != 0) host_pop();
    n_checks++; if (host_empty_o !== 1'b1) $display("FAIL rand_drain got=%b exp=1", host_empty_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_basic_write();
    test_illegal();
    test_tx_full();
    test_rx_full();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
